// File: rtl/qrng_pkg.sv
// ============================================================================
// qrng_pkg : shared types and line-packing helpers for the qubit counter
// Rev 1.0
// ============================================================================
`default_nettype none

package qrng_pkg;

  localparam int MAX_CH           = 8;
  localparam int c_LINES_PER_CH   = 2;
  localparam int c_BIT_ZERO       = 0;
  localparam int c_BIT_ONE        = 1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } win_state_e;

  function automatic int line_idx(input int ch, input int basis);
    return ch * c_LINES_PER_CH + basis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qrng_strobe_sync.sv
// ============================================================================
// qrng_strobe_sync : invert, 2-flop synchronise and rising-edge detect one strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module qrng_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_strobe_n,
  output logic o_evt
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ~i_strobe_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_evt = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/qrng_multi_qubit_counter.sv
// ============================================================================
// qrng_multi_qubit_counter : per-channel |0>/|1> counters, windowed snapshots
// Rev 1.0
// ============================================================================
`default_nettype none

module qrng_multi_qubit_counter
  import qrng_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 64,
  parameter int LED_W  = 4,
  parameter int LED_CH = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_CH-1:0]     qubit_n,
  input  logic                    clear,
  output logic [LED_W-1:0]        led,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [NUM_CH*CNT_W-1:0] snap_zero,
  output logic [NUM_CH*CNT_W-1:0] snap_one,
  output logic [NUM_CH-1:0]       sat,
  output logic                    overrun
);

  localparam int c_LINES = c_LINES_PER_CH * NUM_CH;
  localparam int c_WIN_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [c_LINES-1:0] w_evt;

  generate
    for (genvar g = 0; g < c_LINES; g++) begin : g_sync
      qrng_strobe_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_strobe_n (qubit_n[g]),
        .o_evt      (w_evt[g])
      );
    end
  endgenerate

  logic [CNT_W-1:0]       r_cnt0 [NUM_CH];
  logic [CNT_W-1:0]       r_cnt1 [NUM_CH];
  logic [CNT_W-1:0]       w_nxt0 [NUM_CH];
  logic [CNT_W-1:0]       w_nxt1 [NUM_CH];
  logic [NUM_CH-1:0]      w_sat_hit;
  logic [NUM_CH*CNT_W-1:0] w_pack0;
  logic [NUM_CH*CNT_W-1:0] w_pack1;
  logic [c_WIN_W-1:0]     r_win_cnt;
  logic [31:0]            w_pop;
  logic [31:0]            w_win_sum;
  logic                   w_close;
  logic                   w_accept;
  win_state_e             r_state;
  logic [NUM_CH-1:0]      r_sat;
  logic                   r_overrun;
  logic [NUM_CH*CNT_W-1:0] r_snap_zero;
  logic [NUM_CH*CNT_W-1:0] r_snap_one;
  logic [LED_W-1:0]       r_led;
  logic [LED_W-1:0]       w_led_nxt;
  logic [CNT_W:0]         w_bal;

  always_comb begin
    w_sat_hit = '0;
    w_pack0   = '0;
    w_pack1   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_nxt0[c] = r_cnt0[c];
      w_nxt1[c] = r_cnt1[c];
      if (w_evt[line_idx(c, c_BIT_ZERO)]) begin
        if (r_cnt0[c] == c_CNT_MAX) w_sat_hit[c] = 1'b1;
        else                        w_nxt0[c] = r_cnt0[c] + 1'b1;
      end
      if (w_evt[line_idx(c, c_BIT_ONE)]) begin
        if (r_cnt1[c] == c_CNT_MAX) w_sat_hit[c] = 1'b1;
        else                        w_nxt1[c] = r_cnt1[c] + 1'b1;
      end
      w_pack0[c*CNT_W +: CNT_W] = w_nxt0[c];
      w_pack1[c*CNT_W +: CNT_W] = w_nxt1[c];
    end
  end

  assign w_pop     = 32'($countones(w_evt));
  assign w_win_sum = 32'(r_win_cnt) + w_pop;
  assign w_close   = (w_win_sum >= 32'(WINDOW));
  assign w_accept  = (r_state == PENDING) & snap_ready;

  assign w_bal = {1'b0, r_cnt1[LED_CH]} - {1'b0, r_cnt0[LED_CH]};

  generate
    if (LED_W <= CNT_W + 1) begin : g_led_trunc
      assign w_led_nxt = w_bal[LED_W-1:0];
    end else begin : g_led_sext
      assign w_led_nxt = {{(LED_W-CNT_W-1){w_bal[CNT_W]}}, w_bal};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_overrun   <= 1'b0;
      r_win_cnt   <= '0;
      r_sat       <= '0;
      r_snap_zero <= '0;
      r_snap_one  <= '0;
      r_led       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt0[c] <= '0;
        r_cnt1[c] <= '0;
      end
    end else if (clear) begin
      r_state   <= COLLECT;
      r_overrun <= 1'b0;
      r_win_cnt <= '0;
      r_sat     <= '0;
      r_led     <= w_led_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt0[c] <= '0;
        r_cnt1[c] <= '0;
      end
    end else begin
      r_led <= w_led_nxt;
      if (w_close) begin
        // Overshoot events of the closing cycle are folded into the snapshot.
        r_win_cnt <= '0;
        r_sat     <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          r_cnt0[c] <= '0;
          r_cnt1[c] <= '0;
        end
        if (r_state == COLLECT || w_accept) begin
          r_snap_zero <= w_pack0;
          r_snap_one  <= w_pack1;
          r_state     <= PENDING;
        end else begin
          r_overrun <= 1'b1;
        end
      end else begin
        r_win_cnt <= w_win_sum[c_WIN_W-1:0];
        r_sat     <= r_sat | w_sat_hit;
        for (int c = 0; c < NUM_CH; c++) begin
          r_cnt0[c] <= w_nxt0[c];
          r_cnt1[c] <= w_nxt1[c];
        end
        if (w_accept) r_state <= COLLECT;
      end
    end
  end

  assign led        = r_led;
  assign snap_valid = (r_state == PENDING);
  assign snap_zero  = r_snap_zero;
  assign snap_one   = r_snap_one;
  assign sat        = r_sat;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_qrng_multi_qubit_counter.sv
// ============================================================================
// tb_qrng_multi_qubit_counter : randomized windows against a count-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_qrng_multi_qubit_counter;

  localparam int NCH  = 4;
  localparam int WIN  = 64;
  localparam int CMAX = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  qubit_n, qubit_n_s;
  logic        clear, clear_s, snap_ready, snap_ready_s;
  logic [3:0]  led, led_s, sat, sat_s;
  logic        snap_valid, snap_valid_s, overrun, overrun_s;
  logic [31:0] snap_zero, snap_one;
  logic [15:0] snap_zero_s, snap_one_s;

  always #5 clk = ~clk;

  qrng_multi_qubit_counter #(.NUM_CH(4), .CNT_W(8), .WINDOW(64), .LED_W(4), .LED_CH(0)) dut (
    .clk(clk), .rst(rst), .qubit_n(qubit_n), .clear(clear), .led(led),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_zero(snap_zero),
    .snap_one(snap_one), .sat(sat), .overrun(overrun)
  );

  qrng_multi_qubit_counter #(.NUM_CH(4), .CNT_W(4), .WINDOW(64), .LED_W(4), .LED_CH(3)) dut_s (
    .clk(clk), .rst(rst), .qubit_n(qubit_n_s), .clear(clear_s), .led(led_s),
    .snap_valid(snap_valid_s), .snap_ready(snap_ready_s), .snap_zero(snap_zero_s),
    .snap_one(snap_one_s), .sat(sat_s), .overrun(overrun_s)
  );

  // Count-level model of the CNT_W=8 instance
  int        m_c0 [NCH];
  int        m_c1 [NCH];
  int        m_s0 [NCH];
  int        m_s1 [NCH];
  int        m_win;
  bit        m_valid, m_ovr;
  bit [3:0]  m_sat;
  int        checks = 0;
  int        failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset(input bit full);
    for (int c = 0; c < NCH; c++) begin
      m_c0[c] = 0;
      m_c1[c] = 0;
      if (full) begin
        m_s0[c] = 0;
        m_s1[c] = 0;
      end
    end
    m_win = 0; m_valid = 0; m_ovr = 0; m_sat = '0;
  endfunction

  function automatic void m_step(input logic [7:0] ev, input bit rdy);
    int pop;
    bit acc;
    pop = $countones(ev);
    acc = m_valid && rdy;
    for (int c = 0; c < NCH; c++) begin
      if (ev[2*c])   begin if (m_c0[c] == CMAX) m_sat[c] = 1'b1; else m_c0[c]++; end
      if (ev[2*c+1]) begin if (m_c1[c] == CMAX) m_sat[c] = 1'b1; else m_c1[c]++; end
    end
    if (m_win + pop >= WIN) begin
      if (!m_valid || acc) begin
        for (int c = 0; c < NCH; c++) begin m_s0[c] = m_c0[c]; m_s1[c] = m_c1[c]; end
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      for (int c = 0; c < NCH; c++) begin m_c0[c] = 0; m_c1[c] = 0; end
      m_win = 0;
      m_sat = '0;
    end else begin
      m_win += pop;
      if (acc) m_valid = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_pack(input bit one);
    logic [31:0] p;
    p = '0;
    for (int c = 0; c < NCH; c++) p[c*8 +: 8] = 8'(one ? m_s1[c] : m_s0[c]);
    return p;
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] exp_led;
    exp_led = 4'(m_c1[0] - m_c0[0]);
    chk($sformatf("%s.led", tag), 64'(led), 64'(exp_led));
    chk($sformatf("%s.snap_valid", tag), 64'(snap_valid), 64'(m_valid));
    chk($sformatf("%s.overrun", tag), 64'(overrun), 64'(m_ovr));
    chk($sformatf("%s.sat", tag), 64'(sat), 64'(m_sat));
    chk($sformatf("%s.snap_zero", tag), 64'(snap_zero), 64'(m_pack(1'b0)));
    chk($sformatf("%s.snap_one", tag), 64'(snap_one), 64'(m_pack(1'b1)));
  endtask

  // One strobe batch; acc raises snap_ready exactly in the cycle its events are counted
  task automatic batch(input bit which, input logic [7:0] mask, input bit acc);
    @(negedge clk);
    if (which) qubit_n_s = ~mask; else qubit_n = ~mask;
    @(negedge clk);
    @(negedge clk);
    if (acc) snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    if (!which) m_step(mask, acc);
    @(negedge clk);
    qubit_n   = 8'hFF;
    qubit_n_s = 8'hFF;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_accept();
    @(negedge clk);
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_reset(1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_window(input bit acc_at_close);
    logic [7:0] mask;
    bit closing;
    for (int i = 0; i < 200; i++) begin
      mask    = 8'($urandom_range(1, 255));
      closing = (m_win + $countones(mask)) >= WIN;
      batch(1'b0, mask, acc_at_close && closing);
      if (closing) break;
    end
  endtask

  initial begin
    qubit_n = 8'hFF; qubit_n_s = 8'hFF;
    clear = 1'b0; clear_s = 1'b0; snap_ready = 1'b0; snap_ready_s = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset(1'b1);
    @(negedge clk);
    check_all("reset");
    chk("reset.led_s", 64'(led_s), 64'd0);

    for (int i = 1; i <= 5; i++) begin
      batch(1'b0, 8'h02, 1'b0);
      check_all($sformatf("t1.p%0d", i));
    end
    chk("t1.led5", 64'(led), 64'd5);

    do_clear();
    repeat (7) batch(1'b0, 8'h02, 1'b0);
    repeat (9) batch(1'b0, 8'h01, 1'b0);
    check_all("t2.bal");
    chk("t2.led_neg2", 64'(led), 64'hE);
    batch(1'b0, 8'h30, 1'b0);
    fill_window(1'b0);
    check_all("t2.win");
    do_accept();

    do_clear();
    fill_window(1'b0);
    check_all("t3.win1");
    chk("t3.valid", 64'(snap_valid), 64'd1);
    fill_window(1'b0);
    check_all("t3.win2");
    chk("t3.overrun", 64'(overrun), 64'd1);
    do_accept();
    check_all("t3.accept");

    for (int i = 0; i < 14; i++) batch(1'b1, 8'h40, 1'b0);
    chk("t4.led14", 64'(led_s), 64'h2);
    chk("t4.sat14", 64'(sat_s), 64'h0);
    for (int i = 0; i < 6; i++) batch(1'b1, 8'h40, 1'b0);
    chk("t4.led20", 64'(led_s), 64'h1);
    chk("t4.sat20", 64'(sat_s), 64'h8);
    chk("t4.novalid", 64'(snap_valid_s), 64'h0);
    repeat (7) batch(1'b1, 8'h3F, 1'b0);
    chk("t4.sat62", 64'(sat_s), 64'h8);
    batch(1'b1, 8'h03, 1'b0);
    chk("t4.valid", 64'(snap_valid_s), 64'h1);
    chk("t4.snap_zero", 64'(snap_zero_s), 64'hF778);
    chk("t4.snap_one", 64'(snap_one_s), 64'h0778);
    chk("t4.sat_clr", 64'(sat_s), 64'h0);
    chk("t4.led_clr", 64'(led_s), 64'h0);
    chk("t4.overrun", 64'(overrun_s), 64'h0);

    do_clear();
    fill_window(1'b0);
    check_all("t6.win1");
    fill_window(1'b1);
    check_all("t6.win2");
    chk("t6.no_overrun", 64'(overrun), 64'd0);
    chk("t6.valid", 64'(snap_valid), 64'd1);
    do_accept();

    batch(1'b0, 8'h02, 1'b0);
    @(negedge clk);
    qubit_n = ~8'h0F;
    @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    qubit_n = 8'hFF;
    m_reset(1'b0);
    repeat (3) @(negedge clk);
    check_all("t5.clear");

    @(negedge clk);
    qubit_n = ~8'hF0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    qubit_n = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset(1'b1);
    repeat (5) @(negedge clk);
    check_all("t5.rst");
    batch(1'b0, 8'h02, 1'b0);
    check_all("t5.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
